// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   RAW-hazard interlock that sits beside the ID stage. It keeps a tag pipeline
//   of in-flight register writes, from EX up to the last stage before writeback.
//   It raises stall when the instruction in ID reads a register that still has
//   a write pending.
//
// Ports
//   clk                      rising-edge clock
//   rst                      asynchronous reset, active low
//   id_valid                 ID holds a real instruction
//   id_rs, id_rt             source register indices
//   id_rs_used, id_rt_used   source is actually read
//   id_rd                    destination register index
//   id_regwrite              instruction writes id_rd
//   id_is_load               destination value comes from memory
//   id_nostall               instruction is exempt from the interlock
//   flush                    ID is squashed this cycle
//   hold                     global pipeline freeze
//   stall                    combinational; hold PC/IF-ID and inject a bubble
//   issue                    combinational; ID instruction enters EX at this edge
//   busy_vec                 bit r set while any valid entry targets r
//   stall_cnt                saturating count of stall cycles
module hazard_scoreboard #(
    parameter int NUM_REGS    = 8,
    parameter int REG_BITS    = 3,
    parameter int DEPTH       = 2,
    parameter int FWD_EN      = 0,
    parameter int ZERO_REG_EN = 0,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs,
    input  logic [REG_BITS-1:0] id_rt,
    input  logic                id_rs_used,
    input  logic                id_rt_used,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic                id_regwrite,
    input  logic                id_is_load,
    input  logic                id_nostall,
    input  logic                flush,
    input  logic                hold,
    output logic                stall,
    output logic                issue,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [CNT_W-1:0]    stall_cnt
);

    logic [DEPTH-1:0]    ent_v;
    logic [REG_BITS-1:0] ent_rd [DEPTH];
    // The load flag only matters in EX (load-use check), so it is kept for
    // entry 0 alone instead of being shifted down the whole pipeline.
    logic                ent0_ld;

    logic rs_chk, rt_chk;
    logic hit_rs, hit_rt;

    always_comb begin
        busy_vec = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (ent_v[k]) begin
                busy_vec[ent_rd[k]] = 1'b1;
            end
        end
    end

    always_comb begin
        rs_chk = id_rs_used && ((ZERO_REG_EN == 0) || (id_rs != '0));
        rt_chk = id_rt_used && ((ZERO_REG_EN == 0) || (id_rt != '0));
        if (FWD_EN != 0) begin
            // Full forwarding covers everything except a load still in EX.
            hit_rs = ent_v[0] && ent0_ld && (ent_rd[0] == id_rs);
            hit_rt = ent_v[0] && ent0_ld && (ent_rd[0] == id_rt);
        end else begin
            hit_rs = busy_vec[id_rs];
            hit_rt = busy_vec[id_rt];
        end
    end

    assign stall = id_valid && !id_nostall && !flush &&
                   ((rs_chk && hit_rs) || (rt_chk && hit_rt));
    assign issue = id_valid && !flush && !stall && !hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_v     <= '0;
            ent0_ld   <= 1'b0;
            stall_cnt <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                ent_rd[k] <= '0;
            end
        end else if (!hold) begin
            // The last entry simply falls off: writeback is bypassed in the
            // register file, so it no longer needs tracking.
            for (int k = DEPTH - 1; k > 0; k--) begin
                ent_v[k]  <= ent_v[k-1];
                ent_rd[k] <= ent_rd[k-1];
            end
            ent_v[0]  <= issue && id_regwrite;
            ent_rd[0] <= issue ? id_rd : '0;
            ent0_ld   <= issue && id_is_load;
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard. Two instances share the stimulus: one with default
// parameters (no forwarding) and one with forwarding, hardwired r0 and a
// 4-bit counter. The reference model keeps a time-stamped log of issued writes
// for each instance.
module tb_hazard_scoreboard;

    localparam int DEP  = 2;
    localparam int LOGN = 1024;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [2:0] id_rs, id_rt, id_rd;
    logic       id_rs_used, id_rt_used, id_regwrite, id_is_load, id_nostall;
    logic       flush, hold;

    logic       stall_a, issue_a, stall_b, issue_b;
    logic [7:0] busy_a, busy_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    always #5 clk = ~clk;

    hazard_scoreboard dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_is_load(id_is_load), .id_nostall(id_nostall),
        .flush(flush), .hold(hold), .stall(stall_a), .issue(issue_a),
        .busy_vec(busy_a), .stall_cnt(cnt_a)
    );

    hazard_scoreboard #(.FWD_EN(1), .ZERO_REG_EN(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_is_load(id_is_load), .id_nostall(id_nostall),
        .flush(flush), .hold(hold), .stall(stall_b), .issue(issue_b),
        .busy_vec(busy_b), .stall_cnt(cnt_b)
    );

    typedef struct packed {
        logic       v;
        logic [2:0] rs;
        logic [2:0] rt;
        logic       rsu;
        logic       rtu;
        logic [2:0] rd;
        logic       rw;
        logic       ld;
        logic       ns;
    } instr_t;

    typedef struct packed {
        logic [1:0]  stall;
        logic [1:0]  issue;
        logic [7:0]  busy_a;
        logic [7:0]  busy_b;
        logic [15:0] cnt_a;
        logic [15:0] cnt_b;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   failures = 0;

    // model: per instance, a log of what entered EX at each non-hold edge
    bit lg_v  [2][LOGN];
    int lg_rd [2][LOGN];
    bit lg_ld [2][LOGN];
    int adv   [2];
    int cnt   [2];
    int fwd   [2] = '{0, 1};
    int zr    [2] = '{0, 1};
    int cmax  [2] = '{65535, 15};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            adv[d] = 0;
            cnt[d] = 0;
            for (int i = 0; i < LOGN; i++) lg_v[d][i] = 1'b0;
        end
    endtask

    // A write stamped j edges ago (j < DEP) is still pending; j == 0 means EX.
    function automatic bit src_hz(int d, int s, bit used);
        if (!used) return 1'b0;
        if (zr[d] != 0 && s == 0) return 1'b0;
        for (int j = 0; j < DEP; j++) begin
            int sl;
            sl = (adv[d] - j) & (LOGN - 1);
            if (lg_v[d][sl] && lg_rd[d][sl] == s) begin
                if (fwd[d] == 0) return 1'b1;
                if (j == 0 && lg_ld[d][sl]) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [7:0] busy_of(int d);
        logic [7:0] b;
        b = '0;
        for (int j = 0; j < DEP; j++) begin
            int sl;
            sl = (adv[d] - j) & (LOGN - 1);
            if (lg_v[d][sl]) b[lg_rd[d][sl]] = 1'b1;
        end
        return b;
    endfunction

    function automatic instr_t mk(bit v, int rs, int rt, bit rsu, bit rtu,
                                  int rd, bit rw, bit ld, bit ns);
        instr_t x;
        x.v = v; x.rs = 3'(rs); x.rt = 3'(rt); x.rsu = rsu; x.rtu = rtu;
        x.rd = 3'(rd); x.rw = rw; x.ld = ld; x.ns = ns;
        return x;
    endfunction

    // Apply inputs, push this cycle's expectation, then advance the model
    // across the coming edge.
    task automatic step_now(input instr_t x, input bit fl, input bit hd, output bit ia);
        exp_t e;
        bit st[2];
        bit is[2];
        id_valid = x.v; id_rs = x.rs; id_rt = x.rt; id_rs_used = x.rsu;
        id_rt_used = x.rtu; id_rd = x.rd; id_regwrite = x.rw; id_is_load = x.ld;
        id_nostall = x.ns; flush = fl; hold = hd;
        for (int d = 0; d < 2; d++) begin
            st[d] = x.v && !x.ns && !fl &&
                    (src_hz(d, int'(x.rs), x.rsu) || src_hz(d, int'(x.rt), x.rtu));
            is[d] = x.v && !fl && !st[d] && !hd;
        end
        e.stall  = {st[1], st[0]};
        e.issue  = {is[1], is[0]};
        e.busy_a = busy_of(0);
        e.busy_b = busy_of(1);
        e.cnt_a  = 16'(cnt[0]);
        e.cnt_b  = 16'(cnt[1]);
        expq.push_back(e);
        if (!hd) begin
            for (int d = 0; d < 2; d++) begin
                int sl;
                if (st[d] && cnt[d] < cmax[d]) cnt[d]++;
                adv[d]++;
                sl = adv[d] & (LOGN - 1);
                lg_v[d][sl]  = is[d] && x.rw;
                lg_rd[d][sl] = int'(x.rd);
                lg_ld[d][sl] = x.ld;
            end
        end
        ia = is[0];
    endtask

    task automatic step(input instr_t x, input bit fl, input bit hd, output bit ia);
        @(posedge clk);
        #1;
        step_now(x, fl, hd, ia);
    endtask

    // Present an instruction until instance A issues it, it is flushed,
    // or 20 cycles pass.
    task automatic send(input instr_t x, input logic [19:0] hm, input logic [19:0] fm);
        bit ia;
        for (int i = 0; i < 20; i++) begin
            step(x, fm[i], hm[i], ia);
            if (ia || fm[i]) break;
        end
    endtask

    task automatic idle();
        bit ia;
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, ia);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                exp_t e;
                e = expq.pop_front();
                chk("stall_a", stall_a, e.stall[0]);
                chk("issue_a", issue_a, e.issue[0]);
                chk("busy_a",  busy_a,  e.busy_a);
                chk("cnt_a",   cnt_a,   e.cnt_a);
                chk("stall_b", stall_b, e.stall[1]);
                chk("issue_b", issue_b, e.issue[1]);
                chk("busy_b",  busy_b,  e.busy_b);
                chk("cnt_b",   cnt_b,   e.cnt_b);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ia;
        logic [19:0] hm, fm;

        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            {id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd} = 14'($urandom);
            {id_regwrite, id_is_load, id_nostall, flush, hold} = 5'($urandom);
            #1;
            chk("rst_busy_a",  busy_a,  8'h00);
            chk("rst_busy_b",  busy_b,  8'h00);
            chk("rst_cnt_a",   cnt_a,   16'h0);
            chk("rst_cnt_b",   cnt_b,   4'h0);
            chk("rst_stall_a", stall_a, 1'b0);
            chk("rst_stall_b", stall_b, 1'b0);
            chk("rst_issue_a", issue_a, id_valid && !flush && !hold);
        end
        id_valid = 1'b0;
        hold     = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // ALU writer r3, then r3 reader
        send(mk(1, 0, 0, 0, 0, 3, 1, 0, 0), '0, '0);
        send(mk(1, 3, 0, 1, 0, 0, 0, 0, 0), '0, '0);
        #1;
        chk("raw_cnt_a", cnt_a, 16'd2);
        chk("raw_cnt_b", cnt_b, 4'd0);

        // load r5, then rt=r5 user
        send(mk(1, 0, 0, 0, 0, 5, 1, 1, 0), '0, '0);
        send(mk(1, 1, 5, 0, 1, 0, 0, 0, 0), '0, '0);
        #1;
        chk("ldu_cnt_a", cnt_a, 16'd4);
        chk("ldu_cnt_b", cnt_b, 4'd1);

        // load r0, then r0 user
        send(mk(1, 0, 0, 0, 0, 0, 1, 1, 0), '0, '0);
        send(mk(1, 0, 0, 1, 0, 0, 0, 0, 0), '0, '0);
        #1;
        chk("r0_cnt_a", cnt_a, 16'd6);
        chk("r0_cnt_b", cnt_b, 4'd1);

        // masking: unused source, then exempt instruction
        send(mk(1, 0, 0, 0, 0, 2, 1, 0, 0), '0, '0);
        send(mk(1, 1, 2, 0, 0, 0, 0, 0, 0), '0, '0);
        send(mk(1, 1, 2, 0, 1, 0, 0, 0, 1), '0, '0);
        #1;
        chk("mask_cnt_a", cnt_a, 16'd6);

        // hold for three cycles in the middle of a two-cycle stall
        send(mk(1, 0, 0, 0, 0, 4, 1, 0, 0), '0, '0);
        send(mk(1, 4, 0, 1, 0, 0, 0, 0, 0), 20'b1110, '0);
        #1;
        chk("hold_cnt_a", cnt_a, 16'd8);
        chk("hold_cnt_b", cnt_b, 4'd1);

        // flush with a hazard present: dropped, bubble in entry 0
        send(mk(1, 0, 0, 0, 0, 6, 1, 0, 0), '0, '0);
        send(mk(1, 6, 0, 1, 0, 0, 0, 0, 0), '0, 20'b1);
        idle();
        #1;
        chk("flush_bubble", busy_a, 8'h40);

        // 20 load-use pairs saturate the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            send(mk(1, 0, 0, 0, 0, 1, 1, 1, 0), '0, '0);
            send(mk(1, 1, 0, 1, 0, 0, 0, 0, 0), '0, '0);
        end
        #1;
        chk("sat_cnt_b", cnt_b, 4'd15);
        chk("sat_cnt_a", cnt_a, 16'd48);

        // reset pulse in the middle of a stall
        send(mk(1, 0, 0, 0, 0, 7, 1, 0, 0), '0, '0);
        @(posedge clk);
        #1;
        id_valid = 1'b1; id_rs = 3'd7; id_rs_used = 1'b1; id_rt_used = 1'b0;
        id_regwrite = 1'b0; id_is_load = 1'b0; id_nostall = 1'b0;
        flush = 1'b0; hold = 1'b0;
        #1;
        chk("pre_rst_stall_a", stall_a, 1'b1);
        rst = 1'b0;
        #1;
        chk("mid_rst_stall_a", stall_a, 1'b0);
        chk("mid_rst_busy_a",  busy_a,  8'h00);
        chk("mid_rst_cnt_a",   cnt_a,   16'h0);
        chk("mid_rst_cnt_b",   cnt_b,   4'h0);
        chk("mid_rst_issue_a", issue_a, 1'b1);
        model_reset();
        #1;
        rst = 1'b1;
        step_now(mk(1, 7, 0, 1, 0, 0, 0, 0, 0), 1'b0, 1'b0, ia);

        // random traffic
        for (int n = 0; n < 300; n++) begin
            instr_t x;
            x = mk(($urandom % 8) != 0, $urandom % 4, $urandom % 4,
                   $urandom % 2, $urandom % 2, $urandom % 4,
                   $urandom % 2, $urandom % 2, ($urandom % 16) == 0);
            for (int i = 0; i < 20; i++) begin
                hm[i] = ($urandom % 8) == 0;
                fm[i] = ($urandom % 12) == 0;
            end
            send(x, hm, fm);
        end

        idle();
        idle();
        @(negedge clk);
        #1;
        chk("queue_drained", 64'(expq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised RAW-hazard interlock for the in-order pipeline, sitting beside the ID stage. It tracks every in-flight register write from EX through the last pre-writeback stage in an internal tag pipeline, and raises `stall` when the instruction in ID reads a register that is still pending. It generalises the fixed EX/MEM comparator in three ways: register count and tracked depth are parameters, a forwarding mode restricts stalls to load-use, and it adds a hold/flush protocol and a stall-cycle counter.

## Interface
- `NUM_REGS`, 8: architectural register count; must be a power of 2, at least 2.
- `REG_BITS`, 3: register index width, equal to log2(`NUM_REGS`).
- `DEPTH`, 2: tracked stages between ID and writeback (entry 0 = EX, entry `DEPTH`-1 = last stage before WB); must be at least 1.
- `FWD_EN`, 0: 0 = stall on any pending match; 1 = full forwarding exists, so stall only on a load in entry 0.
- `ZERO_REG_EN`, 0: 1 = register 0 is hardwired and never causes a hazard.
- `CNT_W`, 16: width of the stall counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (`rst`=0 resets).
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs`, `id_rt`  in  `REG_BITS`  source register indices.
- `id_rs_used`, `id_rt_used`  in  1  source is actually read; decoded upstream.
- `id_rd`  in  `REG_BITS`  destination register index.
- `id_regwrite`  in  1  instruction writes `id_rd`.
- `id_is_load`  in  1  the destination value comes from memory.
- `id_nostall`  in  1  instruction is exempt from interlock (NOP/HALT class).
- `flush`  in  1  a later stage squashes ID this cycle.
- `hold`  in  1  global pipeline freeze (memory wait).
- `stall`  out  1  combinational; holds PC/IF-ID and injects a bubble.
- `issue`  out  1  combinational; the ID instruction enters EX at this edge.
- `busy_vec`  out  `NUM_REGS`  bit r = 1 while any valid entry targets r.
- `stall_cnt`  out  `CNT_W`  saturating count of stall cycles.

## Operation
- Each entry k holds {v, rd, ld}. `busy_vec` = OR over valid entries of onehot(rd).
- Per-source hazard for source s (`rs` or `rt`): the source is used, and `ZERO_REG_EN` is 0 or s ≠ 0, and:
  - when `FWD_EN`=0: some entry k has v=1 and rd=s;
  - when `FWD_EN`=1: entry 0 has v=1, ld=1 and rd=s.
- `stall` = `id_valid` & ~`id_nostall` & ~`flush` & (hazard_rs | hazard_rt).
- `issue` = `id_valid` & ~`flush` & ~`stall` & ~`hold`.
- Shift rule, applied at each edge with `hold`=0:
  - entry[k+1] ← entry[k];
  - entry `DEPTH`-1 retires, since writeback is bypassed inside the register file;
  - entry[0] ← `issue` ? {`id_regwrite`, `id_rd`, `id_is_load`} : {0,0,0}, i.e. a bubble on stall, flush or no valid instruction.
- Entries with v=0 never match, and their rd/ld fields are don't-care.
- With `hold`=1, all entries and `stall_cnt` are frozen and `issue`=0; `stall` is still evaluated.
- `stall_cnt` increments when `stall`=1 and `hold`=0, and saturates at 2^`CNT_W`-1.
- `flush` wins over `stall`: the instruction is dropped, not inserted, and a bubble enters entry 0.

## Timing
- Reset (`rst`=0): all v=0 and `stall_cnt`=0 immediately, without waiting for a clock edge. Consequently `busy_vec`=0 and `stall`=0. `issue` follows its inputs.
- `stall` and `issue` are same-cycle combinational from the ID inputs plus the registered entries; no registered output path.
- Dependent back-to-back pair, writer then reader:
  - `FWD_EN`=0: `DEPTH` stall cycles, reader issues on cycle `DEPTH`+1;
  - `FWD_EN`=1 with a load writer: 1 stall cycle;
  - `FWD_EN`=1 with a non-load writer: 0 stall cycles.
- Reader one instruction behind the writer (one independent instruction between them): `DEPTH`-1 stalls when `FWD_EN`=0.
- Reset asserted mid-stall: `stall` drops in the same cycle; the ID instruction then issues at the first edge after release.
- Same register on both sources, or on a source and `id_rd`: one hazard, with no double counting.

## Test plan
- Reset: drive `rst`=0 with random inputs → `busy_vec`=0x00, `stall_cnt`=0, `stall`=0 while any inputs vary.
- `FWD_EN`=0, `DEPTH`=2: issue rd=3 writer, then rs=3 reader → `stall`=1 for 2 cycles; `issue` on the 3rd cycle; `stall_cnt`=2; `busy_vec`=0x08 for 2 cycles, then 0x00.
- `FWD_EN`=1: load rd=5 followed by rt=5 user → 1 stall cycle. ALU rd=5 followed by a user → 0 stalls. `ZERO_REG_EN`=1 with a load to r0 followed by an r0 user → 0 stalls.
- Masking: pending rd=2 with `id_rt`=2 and `id_rt_used`=0 → `stall`=0. The same case with `id_rt_used`=1 and `id_nostall`=1 → `stall`=0.
- Hold: during a 2-cycle stall, assert `hold` for 3 cycles → `stall` stays 1; `stall_cnt` and `busy_vec` stay frozen; after release the remaining stall cycles complete as normal.
- Flush and saturation:
  - `flush` with a hazard present → `stall`=0, `issue`=0, bubble in entry 0.
  - `CNT_W`=4 with 20 stall cycles → `stall_cnt`=15.
  - Reset pulse mid-stall → `stall`=0 asynchronously.
